// File: rtl/piano_pkg.sv
// Shared constants and types for the piano key-frame debouncer.
//
// Contents:
//   NUM_KEYS         default width of the key bitmap
//   ANGLE_UP_KEY     bit index of the "angle up" key
//   ANGLE_DOWN_KEY   bit index of the "angle down" key
//   CNT_W            width of the per-key debounce counters
//   scan_state_e     scanner FSM state encoding
//   cnt_limit()      last counter value before a change is accepted
package piano_pkg;

   localparam int unsigned NUM_KEYS       = 17;
   localparam int unsigned ANGLE_UP_KEY   = 15;
   localparam int unsigned ANGLE_DOWN_KEY = 14;
   localparam int unsigned CNT_W          = 3;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StScan   = 2'd1,
      StCommit = 2'd2
   } scan_state_e;

   // A key whose counter already holds this value and still differs is accepted.
   function automatic logic [CNT_W-1:0] cnt_limit(input int unsigned frames);
      return CNT_W'(frames - 1);
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector for the frame sync.
//
// Ports:
//   clk         pixel clock, rising edge
//   reset       asynchronous active-high reset
//   vsync       frame sync, already in the clk domain
//   frame_tick  combinational one-cycle pulse on a vsync rising edge
//
// The history flop resets high so a vsync that is already high when reset
// is released is treated as "old" and does not produce a tick.
module frame_tick_gen (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   output logic frame_tick
);

   logic vsync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_q <= 1'b1;
      end else begin
         vsync_q <= vsync;
      end
   end

   assign frame_tick = vsync & ~vsync_q;

endmodule

// File: rtl/key_frame_debouncer.sv
// Frame-based key debouncer.
//
// Once per frame (vsync rising edge) the synchronized key levels are
// snapshotted, then scanned one key per clock. A key whose snapshot differs
// from the accepted level must do so on DEBOUNCE_FRAMES consecutive frames
// before the new level is taken; any frame that matches the accepted level
// clears that key's counter. All accepted changes of a frame are committed
// together, with a single note_ready pulse if anything changed.
//
// Ports:
//   clk         pixel clock, rising edge
//   reset       asynchronous active-high reset
//   vsync       frame sync in the clk domain
//   raw_keys    per-key detector levels, asynchronous to clk
//   key_num     registered debounced key bitmap (bit 15 angle up, bit 14 angle down)
//   note_ready  registered one-cycle pulse when key_num changes
module key_frame_debouncer #(
   parameter int unsigned NUM_KEYS        = piano_pkg::NUM_KEYS,
   parameter int unsigned DEBOUNCE_FRAMES = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vsync,
   input  logic [NUM_KEYS-1:0] raw_keys,
   output logic [NUM_KEYS-1:0] key_num,
   output logic                note_ready
);

   import piano_pkg::*;

   localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = cnt_limit(DEBOUNCE_FRAMES);

   if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 7) begin : g_bad_frames
      $error("DEBOUNCE_FRAMES must be in 1..7");
   end

   // ---------------------------------------------------------------------
   // Input synchronizer and frame tick
   // ---------------------------------------------------------------------
   logic [NUM_KEYS-1:0] sync1_q;
   logic [NUM_KEYS-1:0] raw_s_q;
   logic                frame_tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         raw_s_q <= '0;
      end else begin
         sync1_q <= raw_keys;
         raw_s_q <= sync1_q;
      end
   end

   frame_tick_gen u_frame_tick_gen (
      .clk        (clk),
      .reset      (reset),
      .vsync      (vsync),
      .frame_tick (frame_tick)
   );

   // ---------------------------------------------------------------------
   // Scanner state
   // ---------------------------------------------------------------------
   scan_state_e         state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_KEYS-1:0] snap_q, snap_d;
   logic [NUM_KEYS-1:0] next_q, next_d;
   logic [NUM_KEYS-1:0] key_num_q, key_num_d;
   logic                note_ready_q, note_ready_d;
   logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
   logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      snap_d       = snap_q;
      next_d       = next_q;
      key_num_d    = key_num_q;
      note_ready_d = 1'b0;
      cnt_d        = cnt_q;

      unique case (state_q)
         StIdle: begin
            // Ticks are only honoured here, so a tick during a scan is dropped.
            if (frame_tick) begin
               snap_d  = raw_s_q;
               idx_d   = '0;
               next_d  = key_num_q;
               state_d = StScan;
            end
         end

         StScan: begin
            if (snap_q[idx_q] == key_num_q[idx_q]) begin
               cnt_d[idx_q] = '0;
            end else if (cnt_q[idx_q] == CNT_LIMIT) begin
               next_d[idx_q] = snap_q[idx_q];
               cnt_d[idx_q]  = '0;
            end else begin
               cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
            end

            if (idx_q == LAST_IDX) begin
               state_d = StCommit;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         StCommit: begin
            key_num_d    = next_q;
            note_ready_d = (next_q != key_num_q);
            state_d      = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         snap_q       <= '0;
         next_q       <= '0;
         key_num_q    <= '0;
         note_ready_q <= 1'b0;
         cnt_q        <= '{default: '0};
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         snap_q       <= snap_d;
         next_q       <= next_d;
         key_num_q    <= key_num_d;
         note_ready_q <= note_ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign key_num    = key_num_q;
   assign note_ready = note_ready_q;

   // ---------------------------------------------------------------------
   // Design invariants
   // ---------------------------------------------------------------------
   a_note_one_cycle : assert property (
      @(posedge clk) disable iff (reset) note_ready_q |=> !note_ready_q);

   a_keys_only_on_commit : assert property (
      @(posedge clk) disable iff (reset)
      (state_q != StCommit) |=> (key_num_q == $past(key_num_q)));

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_cnt_chk
      a_cnt_bound : assert property (
         @(posedge clk) disable iff (reset) cnt_q[k] <= CNT_LIMIT);
   end

endmodule

// File: doc/key_frame_debouncer.md
KEY_FRAME_DEBOUNCER -- requirements
Module: key_frame_debouncer

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 17, the width of the key bitmap.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 3, legal 1..7: consecutive frames a changed level must persist before acceptance.
REQ-003 SHALL have port clk, input, 1, the single pixel clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port vsync, input, 1, frame sync in the clk domain; its rising edge marks a frame boundary.
REQ-006 SHALL have port raw_keys, input, NUM_KEYS, per-key detector levels, asynchronous to clk.
REQ-007 SHALL have port key_num, output, NUM_KEYS, registered debounced key bitmap, one bit per key (bits 15/14 = angle up/down).
REQ-008 SHALL have port note_ready, output, 1, registered one-cycle pulse when key_num changes.

Function
REQ-009 SHALL pass raw_keys through a 2-flop synchronizer (raw_s); raw_keys must be stable for 2 clk cycles before a frame tick to be seen.
REQ-010 SHALL register vsync into vsync_d; frame_tick = vsync & ~vsync_d.
REQ-011 SHALL implement FSM IDLE -> SCAN -> COMMIT -> IDLE.
REQ-012 In IDLE on frame_tick: snap <= raw_s, idx <= 0, next <= key_num, state <= SCAN.
REQ-013 In SCAN, one key per cycle for key idx:
 - snap[idx]==key_num[idx]: cnt[idx] <= 0.
 - else if cnt[idx]==DEBOUNCE_FRAMES-1: next[idx] <= snap[idx], cnt[idx] <= 0.
 - else: cnt[idx] <= cnt[idx]+1.
REQ-014 SCAN SHALL last exactly NUM_KEYS cycles; on idx==NUM_KEYS-1, state <= COMMIT.
REQ-015 In COMMIT: key_num <= next, note_ready <= (next != key_num), state <= IDLE.
REQ-016 note_ready SHALL deassert on the following edge, giving a width of exactly 1 cycle.
REQ-017 Latency: key_num/note_ready SHALL update on the (NUM_KEYS+1)th edge after the tick edge (edge 18 by default).
REQ-018 Frame ticks arriving in SCAN or COMMIT SHALL be ignored.
REQ-019 Multiple keys accepted in the same frame SHALL produce one note_ready pulse.
REQ-020 A bounce back to the stable level before acceptance SHALL zero that key's counter (no accumulation across bounces).
REQ-021 With DEBOUNCE_FRAMES=1, a change SHALL be accepted on its first sampled frame.
REQ-022 Counters SHALL be 3 bits; cnt never exceeds DEBOUNCE_FRAMES-1, so no wrap can occur.
REQ-023 key_num SHALL change only in COMMIT; it is constant between commits.

Reset
REQ-024 reset SHALL asynchronously force:
 - key_num=0, note_ready=0, state=IDLE, idx=0
 - all cnt=0, snap=0, next=0, synchronizer flops=0
REQ-025 reset SHALL set vsync_d=1 so vsync already high at reset release does not create a tick.
REQ-026 Reset during SCAN/COMMIT SHALL abort the frame with no commit and no note_ready.

Structure
REQ-027 Shared package piano_pkg SHALL hold NUM_KEYS, ANGLE_UP_KEY=15, ANGLE_DOWN_KEY=14, the FSM state encoding and the counter width.
REQ-028 Rising-edge detection SHALL be a sub-module, frame_tick_gen (clk, reset, vsync -> frame_tick, reset-high history).
REQ-029 Per-key counters SHALL be a register array indexed by idx; no per-key instance.

Verification
REQ-030 Press: raw_keys=0x00008 held 3 frames -> key_num=0x00008 and one note_ready pulse, 18 edges after 3rd tick; none earlier.
REQ-031 Bounce: bit 3 high for frames 1,2, low for 3, high for 4,5,6 -> accepted only after frame 6.
REQ-032 Multi-key: bits 14 and 15 set together for 3 frames -> key_num=0x0C000 with a single 1-cycle note_ready.
REQ-033 Reset in SCAN at idx=7 after 2 qualifying frames -> outputs 0 immediately; 3 further frames are needed to accept.
REQ-034 vsync high at reset release, raw_keys=0x1FFFF -> no tick and no change until the first real vsync rise.
REQ-035 Tick injected during SCAN -> ignored; scan still 17 cycles; exactly one commit per processed frame.
